// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, ID-stage jump classes
// and the register-match helper used by the hazard detection terms.
package hazard_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hu_state_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'd0,
        JUMP_J    = 2'd1,
        JUMP_JR   = 2'd2
    } jump_e;

    localparam int CNT_W = 16;

    // $zero is hard-wired, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that increments while enabled and sticks at all-ones
// instead of wrapping.
module sat_counter
    import hazard_unit_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: detects load-use and jr-register hazards, stalls or
// flushes the front end, and counts stall and branch-flush cycles.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_RegWrite,
    input  logic [4:0]  ID_EX_WriteReg,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_WriteReg,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        ID_UsesRt,
    input  logic [1:0]  ID_Jump,
    input  logic        EX_BranchTaken,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount,
    output logic        dbg_state_o
);

    hu_state_e state_q;

    logic is_jr;
    logic is_jump;
    logic haz_lu;
    logic haz_jrl;
    logic haz_jra;
    logic haz_jrm;
    logic stall;

    assign is_jr   = (ID_Jump == 2'(JUMP_JR));
    assign is_jump = (ID_Jump != 2'(JUMP_NONE));

    assign haz_lu  = ID_EX_MemRead &&
                     (reg_match(ID_EX_WriteReg, IF_ID_rs) ||
                      (ID_UsesRt && reg_match(ID_EX_WriteReg, IF_ID_rt)));
    assign haz_jrl = is_jr && ID_EX_MemRead && reg_match(ID_EX_WriteReg, IF_ID_rs);
    assign haz_jra = is_jr && ID_EX_RegWrite && !ID_EX_MemRead &&
                     reg_match(ID_EX_WriteReg, IF_ID_rs);
    assign haz_jrm = is_jr && EX_MEM_MemRead && reg_match(EX_MEM_WriteReg, IF_ID_rs);

    // A taken branch squashes the ID instruction, so any hazard it carried is moot.
    assign stall = !EX_BranchTaken &&
                   ((state_q == ST_HOLD) || haz_lu || haz_jrl || haz_jra || haz_jrm);

    // jr waiting on a load in EX needs the value through MEM/WB: one extra cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (EX_BranchTaken) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  state_q <= haz_jrl ? ST_HOLD : ST_RUN;
                ST_HOLD: state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (is_jump) begin
            IF_ID_Flush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .en_i    (stall),
        .count_o (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .en_i    (EX_BranchTaken),
        .count_o (FlushCount)
    );

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a rule-level reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, ID_UsesRt, EX_BranchTaken;
    logic [4:0]  ID_EX_WriteReg, EX_MEM_WriteReg, IF_ID_rs, IF_ID_rt;
    logic [1:0]  ID_Jump;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, dbg_state_o;
    logic [15:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    // Reference model: extra stall cycles still owed, and the counts the
    // DUT's counters must show after the coming rising edge.
    int m_extra = 0;
    int m_scnt  = 0;
    int m_fcnt  = 0;

    hazard_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_RegWrite  (ID_EX_RegWrite),
        .ID_EX_WriteReg  (ID_EX_WriteReg),
        .EX_MEM_MemRead  (EX_MEM_MemRead),
        .EX_MEM_WriteReg (EX_MEM_WriteReg),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .ID_UsesRt       (ID_UsesRt),
        .ID_Jump         (ID_Jump),
        .EX_BranchTaken  (EX_BranchTaken),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .StallCount      (StallCount),
        .FlushCount      (FlushCount),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        bit lu, jrl, jra, jrm, br, st;
        int e_pc, e_ifw, e_iff, e_idf;
        if (reset) begin
            m_extra = 0;
            m_scnt  = 0;
            m_fcnt  = 0;
        end
        br  = EX_BranchTaken;
        lu  = ID_EX_MemRead && (same_reg(ID_EX_WriteReg, IF_ID_rs) ||
                                (ID_UsesRt && same_reg(ID_EX_WriteReg, IF_ID_rt)));
        jrl = (ID_Jump == 2) && ID_EX_MemRead && same_reg(ID_EX_WriteReg, IF_ID_rs);
        jra = (ID_Jump == 2) && ID_EX_RegWrite && !ID_EX_MemRead &&
              same_reg(ID_EX_WriteReg, IF_ID_rs);
        jrm = (ID_Jump == 2) && EX_MEM_MemRead && same_reg(EX_MEM_WriteReg, IF_ID_rs);
        st  = !br && ((m_extra > 0) || lu || jrl || jra || jrm);

        if (br)                begin e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
        else if (st)           begin e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1; end
        else if (ID_Jump != 0) begin e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 0; end
        else                   begin e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; end

        chk("m_pc_write",    32'(PC_Write),    32'(e_pc));
        chk("m_if_id_write", 32'(IF_ID_Write), 32'(e_ifw));
        chk("m_if_id_flush", 32'(IF_ID_Flush), 32'(e_iff));
        chk("m_id_ex_flush", 32'(ID_EX_Flush), 32'(e_idf));
        chk("m_stall_count", 32'(StallCount),  32'(m_scnt));
        chk("m_flush_count", 32'(FlushCount),  32'(m_fcnt));
        chk("m_state",       32'(dbg_state_o), (m_extra > 0) ? 32'd1 : 32'd0);

        if (!reset) begin
            if (st && m_scnt < 65535) m_scnt++;
            if (br && m_fcnt < 65535) m_fcnt++;
            if (br || m_extra > 0) m_extra = 0;
            else                   m_extra = jrl ? 1 : 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        ID_EX_MemRead   = 0;
        ID_EX_RegWrite  = 0;
        ID_EX_WriteReg  = 0;
        EX_MEM_MemRead  = 0;
        EX_MEM_WriteReg = 0;
        IF_ID_rs        = 0;
        IF_ID_rt        = 0;
        ID_UsesRt       = 0;
        ID_Jump         = 0;
        EX_BranchTaken  = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        set_idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        case ($urandom_range(0, 4))
            0: r = 5'd0;
            1: r = 5'd5;
            2: r = 5'd9;
            3: r = 5'd31;
            default: r = 5'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    task automatic drive_random();
        ID_EX_MemRead   = ($urandom_range(0, 2) == 0);
        ID_EX_RegWrite  = ($urandom_range(0, 1) == 0);
        ID_EX_WriteReg  = pick_reg();
        EX_MEM_MemRead  = ($urandom_range(0, 2) == 0);
        EX_MEM_WriteReg = pick_reg();
        IF_ID_rs        = pick_reg();
        IF_ID_rt        = pick_reg();
        ID_UsesRt       = ($urandom_range(0, 1) == 0);
        ID_Jump         = 2'($urandom_range(0, 3));
        EX_BranchTaken  = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        reset = 1;
        step();
        step();
        reset = 0;
        @(negedge clk);
        chk("rst_stall_count", 32'(StallCount), 32'd0);
        chk("rst_flush_count", 32'(FlushCount), 32'd0);
        chk("rst_pc_write",    32'(PC_Write),   32'd1);
        chk("rst_state",       32'(dbg_state_o), 32'd0);

        // load-use on rs
        step();
        ID_EX_MemRead = 1; ID_EX_WriteReg = 8; IF_ID_rs = 8;
        @(negedge clk);
        chk("lu_pc_write",    32'(PC_Write),    32'd0);
        chk("lu_if_id_write", 32'(IF_ID_Write), 32'd0);
        chk("lu_id_ex_flush", 32'(ID_EX_Flush), 32'd1);
        step();
        set_idle();
        @(negedge clk);
        chk("lu_stall_count", 32'(StallCount), 32'd1);
        chk("lu_released",    32'(PC_Write),   32'd1);

        // register 0 never matches
        do_reset();
        ID_EX_MemRead = 1; ID_UsesRt = 1;
        @(negedge clk);
        chk("r0_pc_write", 32'(PC_Write), 32'd1);
        step();
        set_idle();
        @(negedge clk);
        chk("r0_stall_count", 32'(StallCount), 32'd0);

        // jr after load: two stall cycles
        do_reset();
        ID_Jump = 2; ID_EX_MemRead = 1; ID_EX_WriteReg = 31; IF_ID_rs = 31;
        @(negedge clk);
        chk("jrl_c1_pc_write", 32'(PC_Write),    32'd0);
        chk("jrl_c1_state",    32'(dbg_state_o), 32'd0);
        step();
        set_idle();
        @(negedge clk);
        chk("jrl_c2_pc_write", 32'(PC_Write),    32'd0);
        chk("jrl_c2_state",    32'(dbg_state_o), 32'd1);
        step();
        @(negedge clk);
        chk("jrl_c3_pc_write",  32'(PC_Write),    32'd1);
        chk("jrl_c3_state",     32'(dbg_state_o), 32'd0);
        chk("jrl_stall_count",  32'(StallCount),  32'd2);

        // branch beats load-use
        do_reset();
        ID_EX_MemRead = 1; ID_EX_WriteReg = 8; IF_ID_rs = 8; EX_BranchTaken = 1;
        @(negedge clk);
        chk("br_if_id_flush", 32'(IF_ID_Flush), 32'd1);
        chk("br_id_ex_flush", 32'(ID_EX_Flush), 32'd1);
        chk("br_pc_write",    32'(PC_Write),    32'd1);
        step();
        set_idle();
        @(negedge clk);
        chk("br_stall_count", 32'(StallCount), 32'd0);
        chk("br_flush_count", 32'(FlushCount), 32'd1);

        // plain jump
        do_reset();
        ID_Jump = 1;
        @(negedge clk);
        chk("j_if_id_flush", 32'(IF_ID_Flush), 32'd1);
        chk("j_id_ex_flush", 32'(ID_EX_Flush), 32'd0);
        chk("j_pc_write",    32'(PC_Write),    32'd1);

        // reset in the middle of HOLD
        do_reset();
        ID_Jump = 2; ID_EX_MemRead = 1; ID_EX_WriteReg = 31; IF_ID_rs = 31;
        step();
        set_idle();
        @(negedge clk);
        chk("hold_before_rst", 32'(dbg_state_o), 32'd1);
        #1;
        reset = 1;
        #1;
        chk("hold_rst_state",       32'(dbg_state_o), 32'd0);
        chk("hold_rst_pc_write",    32'(PC_Write),    32'd1);
        chk("hold_rst_stall_count", 32'(StallCount),  32'd0);
        step();
        step();
        reset = 0;
        @(negedge clk);
        chk("hold_rst_after_pc", 32'(PC_Write), 32'd1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 149) == 0);
            drive_random();
        end
        step();
        reset = 0;
        set_idle();

        // saturation: far more stall cycles than the counter can hold
        do_reset();
        ID_EX_MemRead = 1; ID_EX_WriteReg = 8; IF_ID_rs = 8;
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        @(negedge clk);
        chk("sat_stall_count", 32'(StallCount), 32'h0000ffff);
        chk("sat_flush_count", 32'(FlushCount), 32'd0);
        step();
        set_idle();
        @(negedge clk);
        chk("sat_stall_hold", 32'(StallCount), 32'h0000ffff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
